spill_fill_manager: RTL and testbench

// Buffer manager that arbitrates spill/fill requests from N_PORTS frontier FIFOs (spill-capable queues) and moves words to/from external memory.

---
 rtl/spill_fill_manager.sv | 215 +++++++++++++++++++++
 tb/tb_spill_fill_manager.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spill_fill_manager.sv
// spill_fill_manager: arbitrates FIFO spill/fill bursts into per-port
// LIFO regions of external memory.
module spill_fill_manager #(
  parameter int N_PORTS      = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 20,
  parameter int REGION_WORDS = 65536,
  parameter int BURST_LEN    = 32,
  localparam int LW = $clog2(REGION_WORDS) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS-1:0]            spill_req,
  output logic [N_PORTS-1:0]            spill_grant,
  input  logic [N_PORTS*DATA_WIDTH-1:0] spill_data,
  input  logic [N_PORTS-1:0]            spill_data_valid,
  output logic [N_PORTS-1:0]            spill_data_ready,
  input  logic [N_PORTS-1:0]            fill_req,
  output logic [N_PORTS-1:0]            fill_grant,
  output logic [DATA_WIDTH-1:0]         fill_data,
  output logic [N_PORTS-1:0]            fill_data_valid,
  input  logic [N_PORTS-1:0]            fill_data_ready,
  output logic                          mem_wr_en,
  output logic [ADDR_WIDTH-1:0]         mem_wr_addr,
  output logic [DATA_WIDTH-1:0]         mem_wr_data,
  input  logic                          mem_wr_ready,
  output logic                          mem_rd_req,
  output logic [ADDR_WIDTH-1:0]         mem_rd_addr,
  input  logic                          mem_rd_ready,
  input  logic                          mem_rd_valid,
  input  logic [DATA_WIDTH-1:0]         mem_rd_data,
  output logic [N_PORTS*LW-1:0]         region_level,
  output logic                          busy
);

  localparam int OW = $clog2(REGION_WORDS);
  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, SPILL, FILL_RD, FILL_WAIT, FILL_PUSH, RELEASE
  } state_t;

  state_t state, state_d;

  logic [LW-1:0]         level [N_PORTS];
  logic [IW-1:0]         gnt, sp_ptr, fl_ptr;
  logic [IW-1:0]         sp_win, fl_win;
  logic [BW-1:0]         burst_cnt;
  logic                  first, rel_cnt;
  logic [N_PORTS-1:0]    sp_elig, fl_elig;
  logic                  sp_any, fl_any;
  logic [LW-1:0]         lvl_g, lvl_m1;
  logic                  lvl_full, sp_valid_g;
  logic                  sp_xfer, fl_xfer;
  logic [ADDR_WIDTH-1:0] base_g, wr_addr, rd_addr;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
    return (int'(p) == N_PORTS - 1) ? '0 : p + IW'(1);
  endfunction

  assign lvl_g      = level[gnt];
  assign lvl_m1     = lvl_g - LW'(1);
  assign lvl_full   = lvl_g >= LW'(REGION_WORDS);
  assign sp_valid_g = spill_data_valid[gnt];
  assign base_g     = ADDR_WIDTH'(gnt) << OW;
  assign wr_addr    = base_g | ADDR_WIDTH'(lvl_g[OW-1:0]);
  assign rd_addr    = base_g | ADDR_WIDTH'(lvl_m1[OW-1:0]);
  assign busy       = state != IDLE;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_lvl
    assign region_level[p*LW +: LW] = level[p];
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      sp_elig[i] = spill_req[i] && (level[i] < LW'(REGION_WORDS));
      fl_elig[i] = fill_req[i] && (level[i] != '0);
    end
  end

  // Round-robin search starting at each class pointer
  always_comb begin
    int ks, kf;
    ks = 0;
    kf = 0;
    sp_any = 1'b0;
    fl_any = 1'b0;
    sp_win = '0;
    fl_win = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      ks = int'(sp_ptr) + i;
      kf = int'(fl_ptr) + i;
      if (ks >= N_PORTS) ks = ks - N_PORTS;
      if (kf >= N_PORTS) kf = kf - N_PORTS;
      if (!sp_any && sp_elig[ks]) begin
        sp_any = 1'b1;
        sp_win = IW'(ks);
      end
      if (!fl_any && fl_elig[kf]) begin
        fl_any = 1'b1;
        fl_win = IW'(kf);
      end
    end
  end

  always_comb begin
    state_d          = state;
    spill_data_ready = '0;
    fill_data_valid  = '0;
    mem_wr_en        = 1'b0;
    mem_wr_addr      = '0;
    mem_wr_data      = '0;
    mem_rd_req       = 1'b0;
    mem_rd_addr      = '0;
    sp_xfer          = 1'b0;
    fl_xfer          = 1'b0;
    unique case (state)
      IDLE: begin
        if (sp_any)      state_d = SPILL;
        else if (fl_any) state_d = FILL_RD;
      end
      SPILL: begin
        spill_data_ready[gnt] = mem_wr_ready && !lvl_full;
        sp_xfer     = sp_valid_g && mem_wr_ready && !lvl_full;
        mem_wr_en   = sp_xfer;
        mem_wr_addr = wr_addr;
        mem_wr_data = spill_data[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
        // FIFO raises valid one cycle after grant
        if (sp_xfer && (burst_cnt == BW'(BURST_LEN - 1) ||
                        lvl_g == LW'(REGION_WORDS - 1)))
          state_d = RELEASE;
        else if (lvl_full || (!first && !sp_valid_g))
          state_d = RELEASE;
      end
      FILL_RD: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = rd_addr;
        if (mem_rd_ready) state_d = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (mem_rd_valid) state_d = FILL_PUSH;
      end
      FILL_PUSH: begin
        fill_data_valid[gnt] = 1'b1;
        fl_xfer = fill_data_ready[gnt];
        if (fl_xfer) begin
          if (burst_cnt < BW'(BURST_LEN - 1) && lvl_g > LW'(1))
            state_d = FILL_RD;
          else
            state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (rel_cnt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= '0;
      sp_ptr      <= '0;
      fl_ptr      <= '0;
      burst_cnt   <= '0;
      first       <= 1'b0;
      rel_cnt     <= 1'b0;
      fill_data   <= '0;
      spill_grant <= '0;
      fill_grant  <= '0;
      for (int i = 0; i < N_PORTS; i++) level[i] <= '0;
    end else begin
      state <= state_d;
      first <= 1'b0;
      unique case (state)
        IDLE: begin
          burst_cnt <= '0;
          rel_cnt   <= 1'b0;
          if (sp_any) begin
            gnt         <= sp_win;
            sp_ptr      <= nxt(sp_win);
            spill_grant <= N_PORTS'(1) << sp_win;
            first       <= 1'b1;
          end else if (fl_any) begin
            gnt        <= fl_win;
            fl_ptr     <= nxt(fl_win);
            fill_grant <= N_PORTS'(1) << fl_win;
          end
        end
        SPILL: begin
          if (sp_xfer) begin
            level[gnt] <= lvl_g + LW'(1);
            burst_cnt  <= burst_cnt + BW'(1);
          end
          if (state_d == RELEASE) spill_grant <= '0;
        end
        FILL_WAIT: begin
          if (mem_rd_valid) fill_data <= mem_rd_data;
        end
        FILL_PUSH: begin
          if (fl_xfer) begin
            level[gnt] <= lvl_m1;
            burst_cnt  <= burst_cnt + BW'(1);
          end
          if (state_d == RELEASE) fill_grant <= '0;
        end
        RELEASE: rel_cnt <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spill_fill_manager.sv
// tb_spill_fill_manager: directed scenarios against FIFO and memory
// models with hand-computed expectations.
module tb_spill_fill_manager;

  localparam int NP = 2;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 64;
  localparam int BL = 32;
  localparam int LW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0]    spill_req = '0, spill_grant;
  logic [NP*DW-1:0] spill_data = '0;
  logic [NP-1:0]    spill_data_valid = '0, spill_data_ready;
  logic [NP-1:0]    fill_req = '0, fill_grant;
  logic [DW-1:0]    fill_data;
  logic [NP-1:0]    fill_data_valid, fill_data_ready = '1;
  logic             mem_wr_en, mem_wr_ready = 1'b1;
  logic [AW-1:0]    mem_wr_addr, mem_rd_addr;
  logic [DW-1:0]    mem_wr_data, mem_rd_data = '0;
  logic             mem_rd_req, mem_rd_ready = 1'b1;
  logic             mem_rd_valid = 1'b0;
  logic [NP*LW-1:0] region_level;
  logic             busy;

  spill_fill_manager #(
    .N_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .REGION_WORDS(RW), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst),
    .spill_req(spill_req), .spill_grant(spill_grant),
    .spill_data(spill_data),
    .spill_data_valid(spill_data_valid),
    .spill_data_ready(spill_data_ready),
    .fill_req(fill_req), .fill_grant(fill_grant),
    .fill_data(fill_data),
    .fill_data_valid(fill_data_valid),
    .fill_data_ready(fill_data_ready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_ready(mem_rd_ready), .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data),
    .region_level(region_level), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total = 0;

  int sp_cnt[NP], sp_seq[NP], push_count[NP];
  bit sp_en[NP], fl_en[NP], prev_sg[NP], pg_sp[NP], pg_fl[NP];
  logic [DW-1:0] mem [256];
  int wr_count, early_fill, fdr_low, rd_timer;
  bit wr_toggle, rd_pend;
  logic [AW-1:0] rd_a;
  logic [AW-1:0] wr_addrs[$], rd_addrs[$];
  logic [DW-1:0] pushed[$];
  int sp_log[$], fl_log[$];

  function automatic logic [DW-1:0] word(int p, int s);
    return DW'((p + 1) << 24) | DW'(s);
  endfunction

  function automatic logic [LW-1:0] lv(int p);
    return region_level[p*LW +: LW];
  endfunction

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      spill_req[p] = sp_en[p] && sp_cnt[p] > 0;
      spill_data_valid[p] = spill_grant[p] && prev_sg[p] && sp_cnt[p] > 0;
      prev_sg[p] = spill_grant[p];
      spill_data[p*DW +: DW] = word(p, sp_seq[p]);
      fill_req[p] = fl_en[p];
    end
    mem_wr_ready = wr_toggle ? ~mem_wr_ready : 1'b1;
    if (fdr_low > 0) begin
      fill_data_ready = '0;
      fdr_low--;
    end else begin
      fill_data_ready = '1;
    end
    mem_rd_ready = 1'b1;
    if (rd_pend && rd_timer > 0) rd_timer--;
    mem_rd_valid = rd_pend && rd_timer == 0;
    mem_rd_data = mem[rd_a];
  endtask

  // Observe handshakes just after the falling edge, then advance one cycle
  task automatic tick();
    #1;
    if (mem_wr_en) begin
      mem[mem_wr_addr] = mem_wr_data;
      wr_addrs.push_back(mem_wr_addr);
      wr_count++;
    end
    for (int p = 0; p < NP; p++) begin
      if (spill_grant[p] && spill_data_valid[p] && spill_data_ready[p]) begin
        sp_cnt[p]--;
        sp_seq[p]++;
      end
      if (fill_data_valid[p] && fill_data_ready[p]) begin
        pushed.push_back(fill_data);
        push_count[p]++;
      end
      if (spill_grant[p] && !pg_sp[p]) sp_log.push_back(p);
      if (fill_grant[p] && !pg_fl[p]) begin
        fl_log.push_back(p);
        if (sp_cnt[0] > 0 || sp_cnt[1] > 0) early_fill++;
      end
      pg_sp[p] = spill_grant[p];
      pg_fl[p] = fill_grant[p];
    end
    if (mem_rd_valid) rd_pend = 1'b0;
    if (mem_rd_req && mem_rd_ready && !rd_pend) begin
      rd_pend = 1'b1;
      rd_timer = 2;
      rd_a = mem_rd_addr;
      rd_addrs.push_back(mem_rd_addr);
    end
    @(posedge clk);
    @(negedge clk);
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < NP; p++) begin
      sp_cnt[p] = 0; sp_seq[p] = 0; push_count[p] = 0;
      sp_en[p] = 0; fl_en[p] = 0; prev_sg[p] = 0;
      pg_sp[p] = 0; pg_fl[p] = 0;
    end
    wr_count = 0; early_fill = 0; fdr_low = 0; rd_timer = 0;
    wr_toggle = 0; rd_pend = 0; rd_a = '0;
    wr_addrs.delete(); rd_addrs.delete(); pushed.delete();
    sp_log.delete(); fl_log.delete();
    drive();
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    drive();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({spill_grant, fill_grant, spill_data_ready, fill_data_valid} !== '0)
      $display("FAIL rst_hs: got %b want 0",
               {spill_grant, fill_grant, spill_data_ready, fill_data_valid});
    else pass_cnt++;
    total++;
    if ({mem_wr_en, mem_rd_req, busy} !== 3'b000)
      $display("FAIL rst_ctl: got %b want 000", {mem_wr_en, mem_rd_req, busy});
    else pass_cnt++;
    total++;
    if (fill_data !== '0) $display("FAIL rst_fd: got %h want 0", fill_data);
    else pass_cnt++;
    total++;
    if (region_level !== '0) $display("FAIL rst_lvl: got %h want 0", region_level);
    else pass_cnt++;
  endtask

  task automatic test_spill();
    int n, rel, bad;
    do_reset();
    sp_en[0] = 1; sp_cnt[0] = 40;
    drive();
    tick();
    total++;
    if (spill_grant !== 2'b01) $display("FAIL sp_lat: got %b want 01", spill_grant);
    else pass_cnt++;
    n = 0;
    while (wr_count < 32 && n < 100) begin tick(); n++; end
    total++;
    if (lv(0) !== 7'd32) $display("FAIL sp_lvl32: got %0d want 32", lv(0));
    else pass_cnt++;
    n = 0; rel = 0;
    while (spill_grant[0] == 1'b0 && n < 10) begin
      if (busy) rel++;
      tick(); n++;
    end
    total++;
    if (rel != 2) $display("FAIL sp_release: got %0d cycles want 2", rel);
    else pass_cnt++;
    n = 0;
    while ((sp_cnt[0] > 0 || busy) && n < 100) begin tick(); n++; end
    total++;
    if (lv(0) !== 7'd40) $display("FAIL sp_lvl40: got %0d want 40", lv(0));
    else pass_cnt++;
    total++;
    if (wr_count != 40) $display("FAIL sp_wrcnt: got %0d want 40", wr_count);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < wr_addrs.size() && i < 40; i++)
      if (wr_addrs[i] != AW'(i) || mem[i] != word(0, i)) bad++;
    total++;
    if (bad != 0) $display("FAIL sp_addr_data: got %0d bad want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    int n, bad, nlog;
    do_reset();
    sp_en[1] = 1; sp_cnt[1] = 5;
    drive();
    n = 0;
    do begin tick(); n++; end while ((sp_cnt[1] > 0 || busy) && n < 60);
    sp_en[1] = 0;
    total++;
    if (lv(1) !== 7'd5) $display("FAIL fl_pre: got %0d want 5", lv(1));
    else pass_cnt++;
    fl_en[1] = 1;
    drive();
    n = 0;
    do begin tick(); n++; end while ((push_count[1] < 5 || busy) && n < 100);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i >= rd_addrs.size() || rd_addrs[i] != AW'(RW + 4 - i)) bad++;
      if (i >= pushed.size() || pushed[i] != word(1, 4 - i)) bad++;
    end
    total++;
    if (bad != 0 || rd_addrs.size() != 5)
      $display("FAIL fl_seq: got %0d bad, %0d reads want 0, 5", bad, rd_addrs.size());
    else pass_cnt++;
    total++;
    if (lv(1) !== 7'd0) $display("FAIL fl_lvl0: got %0d want 0", lv(1));
    else pass_cnt++;
    nlog = fl_log.size();
    repeat (10) tick();
    total++;
    if (fl_log.size() != nlog || push_count[1] != 5 || busy)
      $display("FAIL fl_ignore: got %0d grants %0d pushes want %0d 5",
               fl_log.size(), push_count[1], nlog);
    else pass_cnt++;
  endtask

  task automatic test_arbitration();
    int n;
    longint es, gs;
    do_reset();
    for (int p = 0; p < NP; p++) begin
      sp_en[p] = 1; sp_cnt[p] = 40; fl_en[p] = 1;
    end
    drive();
    n = 0;
    do begin tick(); n++; end
    while ((push_count[0] < 40 || push_count[1] < 40 || busy) && n < 1500);
    total++;
    if (sp_log.size() != 4 || sp_log[0] != 0 || sp_log[1] != 1 || sp_log[2] != 0)
      $display("FAIL arb_spill: got %p want 0 1 0 1", sp_log);
    else pass_cnt++;
    total++;
    if (early_fill != 0) $display("FAIL arb_prio: got %0d early fills want 0", early_fill);
    else pass_cnt++;
    total++;
    if (fl_log.size() < 2 || fl_log[0] != 0 || fl_log[1] != 1)
      $display("FAIL arb_fill: got %p want 0 1 ...", fl_log);
    else pass_cnt++;
    total++;
    if (region_level !== '0) $display("FAIL arb_lvl: got %h want 0", region_level);
    else pass_cnt++;
    es = 0; gs = 0;
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < 40; i++) es += longint'(word(p, i));
    foreach (pushed[i]) gs += longint'(pushed[i]);
    total++;
    if (gs != es || pushed.size() != 80)
      $display("FAIL arb_words: got sum %0d n %0d want %0d 80", gs, pushed.size(), es);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n, bad;
    bit dropped;
    do_reset();
    wr_toggle = 1; sp_en[0] = 1; sp_cnt[0] = 20;
    drive();
    n = 0;
    do begin tick(); n++; end while ((sp_cnt[0] > 0 || busy) && n < 200);
    bad = 0;
    for (int i = 0; i < 20; i++) if (mem[i] != word(0, i)) bad++;
    total++;
    if (wr_count != 20 || lv(0) !== 7'd20 || bad != 0)
      $display("FAIL bp_spill: got %0d wr %0d lvl %0d bad want 20 20 0",
               wr_count, lv(0), bad);
    else pass_cnt++;
    wr_toggle = 0; sp_en[0] = 0; fl_en[0] = 1; dropped = 0;
    drive();
    n = 0;
    do begin
      if (!dropped && push_count[0] == 3) begin fdr_low = 3; dropped = 1; end
      tick(); n++;
    end while ((push_count[0] < 20 || busy) && n < 300);
    fl_en[0] = 0;
    bad = 0;
    for (int i = 0; i < 20; i++)
      if (i >= pushed.size() || pushed[i] != word(0, 19 - i)) bad++;
    total++;
    if (push_count[0] != 20 || pushed.size() != 20)
      $display("FAIL bp_pushes: got %0d want 20", pushed.size());
    else pass_cnt++;
    total++;
    if (bad != 0) $display("FAIL bp_data: got %0d bad want 0", bad);
    else pass_cnt++;
    total++;
    if (lv(0) !== 7'd0 || rd_addrs.size() != 20)
      $display("FAIL bp_lvl: got lvl %0d reads %0d want 0 20", lv(0), rd_addrs.size());
    else pass_cnt++;
  endtask

  task automatic test_full();
    int n, bad, nlog, rdy;
    do_reset();
    sp_en[0] = 1; sp_cnt[0] = 60;
    drive();
    n = 0;
    do begin tick(); n++; end while ((sp_cnt[0] > 0 || busy) && n < 200);
    total++;
    if (lv(0) !== 7'd60) $display("FAIL full_pre: got %0d want 60", lv(0));
    else pass_cnt++;
    sp_cnt[0] = 32;
    drive();
    n = 0;
    do begin tick(); n++; end while ((wr_count < 64 || busy) && n < 100);
    nlog = sp_log.size(); rdy = 0;
    repeat (10) begin
      if (spill_data_ready != '0) rdy++;
      tick();
    end
    total++;
    if (wr_count != 64 || sp_cnt[0] != 28)
      $display("FAIL full_count: got %0d wr %0d left want 64 28", wr_count, sp_cnt[0]);
    else pass_cnt++;
    total++;
    if (lv(0) !== 7'd64) $display("FAIL full_lvl: got %0d want 64", lv(0));
    else pass_cnt++;
    bad = 0;
    for (int i = 60; i < 64; i++) if (mem[i] != word(0, i)) bad++;
    total++;
    if (sp_log.size() != nlog || rdy != 0 || bad != 0)
      $display("FAIL full_inelig: got %0d grants %0d rdy %0d bad want %0d 0 0",
               sp_log.size(), rdy, bad, nlog);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    sp_en[0] = 1; sp_cnt[0] = 40;
    drive();
    n = 0;
    while (wr_count < 8 && n < 50) begin tick(); n++; end
    rst = 1'b1;
    tick();
    total++;
    if ({spill_grant, spill_data_ready, mem_wr_en, busy} !== '0)
      $display("FAIL rmid_out: got %b want 0",
               {spill_grant, spill_data_ready, mem_wr_en, busy});
    else pass_cnt++;
    total++;
    if (region_level !== '0) $display("FAIL rmid_lvl: got %h want 0", region_level);
    else pass_cnt++;
    rst = 1'b0;
    wr_addrs.delete();
    n = 0;
    while (wr_addrs.size() == 0 && n < 20) begin tick(); n++; end
    total++;
    if (wr_addrs.size() == 0 || wr_addrs[0] !== 8'd0)
      $display("FAIL rmid_addr: got %0d writes want first addr 0", wr_addrs.size());
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_spill();
    test_fill();
    test_arbitration();
    test_back_to_back();
    test_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
